dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Handshaked data-memory responder. It serves load/store requests from a multi-cycle or pipelined MIPS core.
- It replaces the combinational dm with a valid/ready request channel and a valid/ready response channel.
- A programmable number of wait states emulates slow memory.
- Word-organised storage with byte-lane write enables. Word index is address bits [DEPTH_LOG2+1:2].

Parameters:
DEPTH_LOG2, 10, log2 of word count (1024 words = 4 KiB)
LATENCY, 2, wait-state cycles between request acceptance and response (legal 0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte-lane enables; bit i controls bits [8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  core accepts response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  request was illegal

Behaviour:
- States are IDLE, BUSY and RESP. A 4-bit wait counter is used in BUSY.
- Reset (rst=0, asynchronous):
  - state = IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; counter = 0.
  - req_ready = 0 while rst is low.
  - Memory contents are not reset.
- req_ready = 1 exactly when state == IDLE and rst is high. It is driven directly from state, with no dependency on req_valid.
- Acceptance happens at edge E0 when req_valid & req_ready. At that edge the block latches we, addr, wdata and be.
  - LATENCY = 0: go to RESP at E0.
  - Otherwise: go to BUSY at E0 with counter = LATENCY-1. Each BUSY cycle decrements the counter. Go to RESP at the edge where counter == 0.
  - Result: resp_valid rises at edge E0+LATENCY and is registered.
- Memory action happens on the edge that enters RESP, once per transaction.
  - Load: resp_rdata = mem[index], full word; req_be is ignored.
  - Store: mem[index] lane i = wdata lane i for each be[i]=1. resp_rdata = 0. be = 0 is a legal no-op.
- Error: resp_err = 1 if either of the following holds:
  - addr[1:0] != 0 (misaligned)
  - addr[31:DEPTH_LOG2+2] != 0 (out of range)
  - On error there is no memory write and resp_rdata = 0. Error and data are presented at the same time as resp_valid.
- RESP state:
  - resp_valid, resp_rdata and resp_err stay stable until resp_valid & resp_ready at edge E1.
  - At E1: state goes to IDLE and resp_valid = 0. resp_rdata and resp_err hold their values (don't care).
  - req_ready returns high in the cycle after E1. There is no same-cycle response/request overlap, so the minimum transaction period is LATENCY+2 cycles.
- resp_ready held high before resp_valid rises has no effect until resp_valid is 1.
- req_* inputs are ignored outside IDLE. Changes to them during BUSY/RESP do not affect the latched transaction.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no response is issued.
  - A store not yet committed (BUSY) never writes.
  - A store already committed (RESP) remains in memory.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Counter width is 4 bits. LATENCY > 15 is illegal (elaboration check).

Test Plan:
- Reset with LATENCY=2. Release rst, then store addr 0x10, wdata 0xDEADBEEF, be 4'hF. Expect req_ready=1 before acceptance, resp_valid high 2 edges after acceptance, resp_err=0 and resp_rdata=0. Then load 0x10 → resp_rdata=0xDEADBEEF.
- Byte lanes: store 0x11223344 to addr 0x20 with be=4'hF, then store 0xAABBCCDD with be=4'b0101. Load 0x20 → 0x11BB33DD.
- Errors: load 0x22 → resp_err=1, rdata=0. Store 0x00001000 (DEPTH_LOG2=10, out of range) → resp_err=1. A later load of 0x0 is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises. Expect resp_valid/rdata/err stable and req_ready=0 throughout. Raise resp_ready: one handshake, then req_ready=1 on the next cycle.
- LATENCY=0 build: back-to-back loads with req_valid held high. Expect acceptances every 2 cycles and resp_valid on the same edge as acceptance.
- Reset mid-BUSY: with LATENCY=3, accept a store 0x55555555 to 0x40 over prior content 0x0. Assert rst one cycle later and release. Expect no response and resp_valid=0. A load of 0x40 → 0x00000000.

Source files
------------

// File: rtl/dm_responder.sv
// Handshaked data-memory responder: valid/ready request and response channels,
// programmable wait states, word storage with byte-lane write enables.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH    = 32'(1) << DEPTH_LOG2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned IDX_W    = DEPTH_LOG2;
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  if (LATENCY > 15) begin : g_latency_check
    $error("dm_responder: LATENCY must be in 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_commit;
  logic               w_src_idle;
  logic               w_we;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [3:0]         w_be;
  logic [IDX_W-1:0]   w_idx;
  logic               w_err;
  logic               w_wen;
  logic [31:0]        w_rd;
  logic [31:0]        w_rdata;

  assign req_ready = (r_state == S_IDLE) && rst;
  assign w_accept  = req_valid && req_ready;

  // With zero wait states the transaction commits on its acceptance edge,
  // so the live request fields are used instead of the latched copies.
  assign w_src_idle = (r_state == S_IDLE);
  assign w_we       = w_src_idle ? req_we    : r_we;
  assign w_addr     = w_src_idle ? req_addr  : r_addr;
  assign w_wdata    = w_src_idle ? req_wdata : r_wdata;
  assign w_be       = w_src_idle ? req_be    : r_be;

  assign w_commit = (ZERO_LAT && w_accept) || ((r_state == S_BUSY) && (r_cnt == '0));
  assign w_idx    = w_addr[DEPTH_LOG2+1:2];
  assign w_err    = (w_addr[1:0] != 2'b00) || ((w_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_wen    = w_commit && w_we && !w_err;
  assign w_rd     = r_mem[w_idx];
  assign w_rdata  = (!w_we && !w_err) ? w_rd : 32'd0;

  // Storage is never reset; byte lanes are written independently.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (ZERO_LAT) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= w_rdata;
              resp_err   <= w_err;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_rdata;
            resp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state    <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 0, 3) checked against a
// word-level memory model held in an associative array.
module tb_dm_responder;

  localparam int unsigned DL2 = 10;
  localparam int unsigned N   = 3;

  logic        clk;
  logic        rst        [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic [3:0]  req_be     [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  int checks;
  int errors;
  logic [31:0] model [int];

  dm_responder #(.DEPTH_LOG2(DL2), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  dm_responder #(.DEPTH_LOG2(DL2), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  dm_responder #(.DEPTH_LOG2(DL2), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit m_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd4 << DL2));
  endfunction

  function automatic int m_key(input int k, input logic [31:0] a);
    return k * 4096 + int'(a / 4);
  endfunction

  function automatic logic [31:0] m_load(input int k, input logic [31:0] a);
    if (m_err(a)) return 32'd0;
    if (!model.exists(m_key(k, a))) return 32'd0;
    return model[m_key(k, a)];
  endfunction

  function automatic void m_store(input int k, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] be);
    logic [31:0] w;
    if (m_err(a)) return;
    w = model.exists(m_key(k, a)) ? model[m_key(k, a)] : 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    model[m_key(k, a)] = w;
  endfunction

  // Drives one transaction and reports what the responder returned.
  task automatic run_txn(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int bp,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output bit stable, output bit done);
    int w;
    done = 1'b0; stable = 1'b1; lat = -1; rdata = '0; err = 1'b0;
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_be[k] = be;
    w = 0;
    while (req_ready[k] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_we[k] = ~we; req_addr[k] = $urandom;
    req_wdata[k] = $urandom; req_be[k] = 4'($urandom);
    lat = 0;
    while (resp_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) return;
    rdata = resp_rdata[k];
    err   = resp_err[k];
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== rdata || resp_err[k] !== err ||
          req_ready[k] !== 1'b0) stable = 1'b0;
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    done = (resp_valid[k] === 1'b0) && (req_ready[k] === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++; if (req_ready[k] !== 1'b0) begin errors++; $display("FAIL reset_req_ready[%0d] got %b want 0", k, req_ready[k]); end
      checks++; if (resp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d] got %b want 0", k, resp_valid[k]); end
      checks++; if (resp_rdata[k] !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata[%0d] got %h want 0", k, resp_rdata[k]); end
      checks++; if (resp_err[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_err[%0d] got %b want 0", k, resp_err[k]); end
    end
    for (int k = 0; k < N; k++) rst[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++; if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL idle_req_ready[%0d] got %b want 1", k, req_ready[k]); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, dn);
    m_store(0, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (lat != lat_of(0)) begin errors++; $display("FAIL basic_store_latency got %0d want %0d", lat, lat_of(0)); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_store_err got %b want 0", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL basic_store_rdata got %h want 0", rd); end
    checks++; if (!dn) begin errors++; $display("FAIL basic_store_handshake got 0 want 1"); end
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, dn);
    checks++; if (rd !== m_load(0, 32'h10)) begin errors++; $display("FAIL basic_load_rdata got %h want %h", rd, m_load(0, 32'h10)); end
    checks++; if (lat != lat_of(0)) begin errors++; $display("FAIL basic_load_latency got %0d want %0d", lat, lat_of(0)); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    run_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, dn);
    m_store(0, 32'h20, 32'h11223344, 4'hF);
    run_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, st, dn);
    m_store(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    run_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, st, dn);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lanes_be0_err got %b want 0", er); end
    run_txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, st, dn);
    checks++; if (rd !== m_load(0, 32'h20)) begin errors++; $display("FAIL lanes_load got %h want %h", rd, m_load(0, 32'h20)); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    run_txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, st, dn);
    m_store(0, 32'h0, 32'hCAFEF00D, 4'hF);
    run_txn(0, 1'b0, 32'h22, 32'h0, 4'hF, 0, rd, er, lat, st, dn);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_load_err got %b want 1", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_misaligned_load_rdata got %h want 0", rd); end
    checks++; if (lat != lat_of(0)) begin errors++; $display("FAIL err_latency got %0d want %0d", lat, lat_of(0)); end
    run_txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 0, rd, er, lat, st, dn);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_range_store_err got %b want 1", er); end
    run_txn(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, st, dn);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_store_err got %b want 1", er); end
    run_txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat, st, dn);
    checks++; if (rd !== m_load(0, 32'h0)) begin errors++; $display("FAIL err_word0_unchanged got %h want %h", rd, m_load(0, 32'h0)); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_word0_err got %b want 0", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    run_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat, st, dn);
    checks++; if (!st) begin errors++; $display("FAIL bp_stable got 0 want 1"); end
    checks++; if (!dn) begin errors++; $display("FAIL bp_handshake got 0 want 1"); end
    checks++; if (rd !== m_load(0, 32'h10)) begin errors++; $display("FAIL bp_rdata got %h want %h", rd, m_load(0, 32'h10)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    logic [31:0] a; logic acc;
    int last; int nacc; int idx;
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(4 * i);
      rd = $urandom;
      run_txn(1, 1'b1, a, rd, 4'hF, 0, rd, er, lat, st, dn);
      m_store(1, a, req_wdata[1] ^ req_wdata[1], 4'h0);
    end
    // Re-store known data so the model tracks exactly what was written.
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(4 * i);
      rd = $urandom;
      m_store(1, a, rd, 4'hF);
      run_txn(1, 1'b1, a, rd, 4'hF, 0, rd, er, lat, st, dn);
    end
    last = -1; nacc = 0; idx = 0;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_be[1] = 4'h0;
    req_addr[1] = 32'h200;
    for (int c = 0; c < 16; c++) begin
      acc = req_valid[1] & req_ready[1];
      a = req_addr[1];
      @(posedge clk); #1;
      if (acc) begin
        checks++; if (resp_valid[1] !== 1'b1) begin errors++; $display("FAIL b2b_same_edge_valid cycle %0d got %b want 1", c, resp_valid[1]); end
        checks++; if (resp_rdata[1] !== m_load(1, a)) begin errors++; $display("FAIL b2b_rdata addr %h got %h want %h", a, resp_rdata[1], m_load(1, a)); end
        if (last >= 0) begin
          checks++; if (c - last != 2) begin errors++; $display("FAIL b2b_spacing got %0d want 2", c - last); end
        end
        last = c; nacc++; idx++;
        req_addr[1] = 32'h200 + 32'(4 * (idx % 8));
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    checks++; if (nacc != 8) begin errors++; $display("FAIL b2b_accept_count got %0d want 8", nacc); end
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    bit saw_valid;
    run_txn(2, 1'b1, 32'h40, 32'h0, 4'hF, 0, rd, er, lat, st, dn);
    m_store(2, 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h40;
    req_wdata[2] = 32'h55555555; req_be[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    #1;
    checks++; if (resp_valid[2] !== 1'b0) begin errors++; $display("FAIL rstbusy_resp_valid got %b want 0", resp_valid[2]); end
    checks++; if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL rstbusy_req_ready got %b want 0", req_ready[2]); end
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid[2] !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin errors++; $display("FAIL rstbusy_no_response got 1 want 0"); end
    run_txn(2, 1'b0, 32'h40, 32'h0, 4'hF, 0, rd, er, lat, st, dn);
    checks++; if (rd !== m_load(2, 32'h40)) begin errors++; $display("FAIL rstbusy_load got %h want %h", rd, m_load(2, 32'h40)); end
    checks++; if (lat != lat_of(2)) begin errors++; $display("FAIL rstbusy_latency got %0d want %0d", lat, lat_of(2)); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; bit st, dn;
    logic [31:0] a, d; logic we; logic [3:0] be; int bp; int r;
    logic [31:0] exp_rd; logic exp_err;
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(4 * i);
      d = $urandom;
      m_store(0, a, d, 4'hF);
      run_txn(0, 1'b1, a, d, 4'hF, 0, rd, er, lat, st, dn);
    end
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      if (r == 1) a = (32'h1000 << $urandom_range(0, 19)) | (32'($urandom) & 32'hFFC);
      we = 1'($urandom);
      be = 4'($urandom);
      d  = $urandom;
      bp = int'($urandom_range(0, 2));
      exp_err = m_err(a);
      exp_rd  = we ? 32'd0 : m_load(0, a);
      if (we) m_store(0, a, d, be);
      run_txn(0, we, a, d, be, bp, rd, er, lat, st, dn);
      checks++; if (er !== exp_err) begin errors++; $display("FAIL rand_err #%0d addr %h got %b want %b", n, a, er, exp_err); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata #%0d addr %h we %b got %h want %h", n, a, we, rd, exp_rd); end
      checks++; if (lat != lat_of(0)) begin errors++; $display("FAIL rand_latency #%0d got %0d want %0d", n, lat, lat_of(0)); end
      checks++; if (!(st && dn)) begin errors++; $display("FAIL rand_handshake #%0d stable %b done %b want 1 1", n, st, dn); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; resp_ready[k] = 1'b0;
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
